// File: rtl/seq_detector_pkg.sv
// Shared types, limits and helpers for the seq_detector_moore block.
package seq_detector_pkg;

    // FILL: history not yet full; SCAN: full, no match; MATCH: last window matched.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SCAN  = 2'd1,
        MATCH = 2'd2
    } seqdet_state_e;

    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 8;
    localparam int unsigned CNT_W_MAX = 32;

    // Increment that sticks at max_val instead of wrapping.
    function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/seq_hit_counter.sv
// Saturating hit counter with synchronous reset, clear and increment.
module seq_hit_counter
    import seq_detector_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_cnt_w_check
        $error("seq_hit_counter: CNT_W must be in 1..32");
    end

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] count_q, count_d;

    // Clear wins over increment; increment saturates at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = CNT_W'(sat_inc(32'(count_q), 32'(CntMax)));
        end
    end

    // Count register, synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detector_moore.sv
// Moore serial pattern detector with runtime-loadable pattern and selectable overlap.
// Build option: define SEQDET_HIT_COUNT_EN to include the saturating hit counter;
// otherwise hit_count_o is tied to zero.
module seq_detector_moore
    import seq_detector_pkg::*;
#(
    parameter int unsigned      PAT_W   = 3,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(3'b101),
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             bit_valid_i,
    input  logic             bit_in_i,
    input  logic             pat_load_i,
    input  logic [PAT_W-1:0] pat_in_i,
    input  logic             overlap_i,
    output logic             detect_o,
    output logic [CNT_W-1:0] hit_count_o,
    output logic             fill_full_o
);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_pat_w_check
        $error("seq_detector_moore: PAT_W must be in 2..8");
    end

    localparam int unsigned FillW = $clog2(PAT_W + 1);

    seqdet_state_e    state_q;
    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] pat_q;
    logic [FillW-1:0] fill_q;
    logic             detect_q;
    logic             fill_full_q;

    logic             accept;
    logic [PAT_W-1:0] hist_shift;
    logic [FillW-1:0] fill_inc;
    logic             now_full;
    logic             win_match;

    // Post-shift window and fill, evaluated for the bit offered this cycle.
    always_comb begin
        accept     = en_i & bit_valid_i & ~pat_load_i;
        hist_shift = {hist_q[PAT_W-2:0], bit_in_i};
        fill_inc   = FillW'(sat_inc(32'(fill_q), PAT_W));
        now_full   = (fill_inc == FillW'(PAT_W));
        win_match  = now_full && (hist_shift == pat_q);
    end

    // Detector FSM with registered detect and fill-full flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FILL;
            hist_q      <= '0;
            fill_q      <= '0;
            pat_q       <= PAT_RST;
            detect_q    <= 1'b0;
            fill_full_q <= 1'b0;
        end else if (pat_load_i) begin
            // Load drops any bit offered in the same cycle.
            state_q     <= FILL;
            hist_q      <= '0;
            fill_q      <= '0;
            pat_q       <= pat_in_i;
            detect_q    <= 1'b0;
            fill_full_q <= 1'b0;
        end else if (accept) begin
            if (win_match) begin
                state_q  <= MATCH;
                detect_q <= 1'b1;
                if (overlap_i) begin
                    hist_q      <= hist_shift;
                    fill_q      <= fill_inc;
                    fill_full_q <= 1'b1;
                end else begin
                    // Non-overlap: the next match must be built from fresh bits.
                    hist_q      <= '0;
                    fill_q      <= '0;
                    fill_full_q <= 1'b0;
                end
            end else begin
                state_q     <= now_full ? SCAN : FILL;
                detect_q    <= 1'b0;
                hist_q      <= hist_shift;
                fill_q      <= fill_inc;
                fill_full_q <= now_full;
            end
        end
    end

    assign detect_o    = detect_q;
    assign fill_full_o = fill_full_q;

`ifdef SEQDET_HIT_COUNT_EN
    logic hit_inc;

    // A hit is every accepted bit that enters or re-enters MATCH.
    always_comb begin
        hit_inc = accept & win_match;
    end

    seq_hit_counter #(
        .CNT_W (CNT_W)
    ) u_hit_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (pat_load_i),
        .inc_i   (hit_inc),
        .count_o (hit_count_o)
    );
`else
    assign hit_count_o = '0;
`endif

endmodule

// File: tb/tb_seq_detector_moore.sv
// Directed bench for seq_detector_moore: three instances (PAT_W 3, 4 and 2) share stimulus.
module tb_seq_detector_moore;

`ifdef SEQDET_HIT_COUNT_EN
    localparam int CntOn = 1;
`else
    localparam int CntOn = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_in = 1'b0;
    logic pat_load = 1'b0;
    logic overlap = 1'b0;
    logic [2:0] pat_in3 = 3'b000;
    logic [3:0] pat_in4 = 4'b0000;
    logic [1:0] pat_in2 = 2'b11;

    logic       det3, full3, det4, full4, det2, full2;
    logic [7:0] cnt3, cnt4;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_detector_moore #(.PAT_W(3), .PAT_RST(3'b101), .CNT_W(8)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .bit_valid_i(bit_valid), .bit_in_i(bit_in),
        .pat_load_i(pat_load), .pat_in_i(pat_in3), .overlap_i(overlap),
        .detect_o(det3), .hit_count_o(cnt3), .fill_full_o(full3)
    );

    seq_detector_moore #(.PAT_W(4), .PAT_RST(4'b1001), .CNT_W(8)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .bit_valid_i(bit_valid), .bit_in_i(bit_in),
        .pat_load_i(pat_load), .pat_in_i(pat_in4), .overlap_i(overlap),
        .detect_o(det4), .hit_count_o(cnt4), .fill_full_o(full4)
    );

    seq_detector_moore #(.PAT_W(2), .PAT_RST(2'b11), .CNT_W(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .bit_valid_i(bit_valid), .bit_in_i(bit_in),
        .pat_load_i(pat_load), .pat_in_i(pat_in2), .overlap_i(overlap),
        .detect_o(det2), .hit_count_o(cnt2), .fill_full_o(full2)
    );

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        step();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        step();
        step();
        rst = 1'b0;
        checks += 9;
        if (det3 !== 1'b0)  begin errors++; $display("FAIL reset det3: got %b want 0", det3); end
        if (full3 !== 1'b0) begin errors++; $display("FAIL reset full3: got %b want 0", full3); end
        if (cnt3 !== 8'd0)  begin errors++; $display("FAIL reset cnt3: got %0d want 0", cnt3); end
        if (det4 !== 1'b0)  begin errors++; $display("FAIL reset det4: got %b want 0", det4); end
        if (full4 !== 1'b0) begin errors++; $display("FAIL reset full4: got %b want 0", full4); end
        if (cnt4 !== 8'd0)  begin errors++; $display("FAIL reset cnt4: got %0d want 0", cnt4); end
        if (det2 !== 1'b0)  begin errors++; $display("FAIL reset det2: got %b want 0", det2); end
        if (full2 !== 1'b0) begin errors++; $display("FAIL reset full2: got %b want 0", full2); end
        if (cnt2 !== 2'd0)  begin errors++; $display("FAIL reset cnt2: got %0d want 0", cnt2); end
    endtask

    // Pattern 101, overlap on or off, bits 1,0,1,0,1.
    task automatic test_overlap_mode(input logic ovl);
        logic bits [5]     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic det_ovl [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic det_nov [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic full_ovl [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic full_nov [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_cnt;
        do_reset();
        en      = 1'b1;
        overlap = ovl;
        for (int i = 0; i < 5; i++) begin
            send_bit(bits[i]);
            checks += 2;
            if (det3 !== (ovl ? det_ovl[i] : det_nov[i])) begin
                errors++;
                $display("FAIL overlap=%b det bit%0d: got %b want %b", ovl, i, det3,
                         ovl ? det_ovl[i] : det_nov[i]);
            end
            if (full3 !== (ovl ? full_ovl[i] : full_nov[i])) begin
                errors++;
                $display("FAIL overlap=%b full bit%0d: got %b want %b", ovl, i, full3,
                         ovl ? full_ovl[i] : full_nov[i]);
            end
        end
        exp_cnt = 8'(CntOn * (ovl ? 2 : 1));
        checks++;
        if (cnt3 !== exp_cnt) begin
            errors++;
            $display("FAIL overlap=%b hit_count: got %0d want %0d", ovl, cnt3, exp_cnt);
        end
    endtask

    // PAT_W=4, pattern 1101, three idle cycles after each accepted bit.
    task automatic test_gaps();
        logic bits [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        en       = 1'b1;
        overlap  = 1'b1;
        pat_in4  = 4'b1101;
        pat_load = 1'b1;
        step();
        pat_load = 1'b0;
        checks++;
        if (det4 !== 1'b0) begin errors++; $display("FAIL gaps load det4: got %b want 0", det4); end
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[i]);
            checks++;
            if (det4 !== (i == 3)) begin
                errors++;
                $display("FAIL gaps det4 bit%0d: got %b want %b", i, det4, (i == 3));
            end
            for (int k = 0; k < 3; k++) begin
                step();
                checks++;
                if (det4 !== (i == 3)) begin
                    errors++;
                    $display("FAIL gaps det4 bit%0d idle%0d: got %b want %b", i, k, det4, (i == 3));
                end
            end
        end
        checks++;
        if (cnt4 !== 8'(CntOn)) begin
            errors++;
            $display("FAIL gaps hit_count: got %0d want %0d", cnt4, CntOn);
        end
    endtask

    // PAT_W=2, CNT_W=2, pattern 11, six 1s: count saturates at 3.
    task automatic test_saturate();
        logic       det_exp [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] cnt_raw [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [1:0] cnt_exp;
        do_reset();
        en      = 1'b1;
        overlap = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_bit(1'b1);
            cnt_exp = (CntOn != 0) ? cnt_raw[i] : 2'd0;
            checks += 2;
            if (det2 !== det_exp[i]) begin
                errors++;
                $display("FAIL saturate det2 bit%0d: got %b want %b", i, det2, det_exp[i]);
            end
            if (cnt2 !== cnt_exp) begin
                errors++;
                $display("FAIL saturate cnt2 bit%0d: got %0d want %0d", i, cnt2, cnt_exp);
            end
        end
    endtask

    // pat_load with a simultaneous valid bit: load wins, bit dropped.
    task automatic test_load_priority();
        do_reset();
        en      = 1'b1;
        overlap = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        checks++;
        if (det3 !== 1'b1) begin errors++; $display("FAIL load pre det3: got %b want 1", det3); end
        pat_in3   = 3'b011;
        pat_load  = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        step();
        pat_load  = 1'b0;
        bit_valid = 1'b0;
        checks += 3;
        if (det3 !== 1'b0)  begin errors++; $display("FAIL load det3: got %b want 0", det3); end
        if (full3 !== 1'b0) begin errors++; $display("FAIL load full3: got %b want 0", full3); end
        if (cnt3 !== 8'd0)  begin errors++; $display("FAIL load cnt3: got %0d want 0", cnt3); end
        // Had the 0 been taken, 1,1 would complete 011 here.
        send_bit(1'b1);
        send_bit(1'b1);
        checks += 2;
        if (det3 !== 1'b0)  begin errors++; $display("FAIL load drop det3: got %b want 0", det3); end
        if (full3 !== 1'b0) begin errors++; $display("FAIL load drop full3: got %b want 0", full3); end
        send_bit(1'b0);
        checks += 2;
        if (det3 !== 1'b0)  begin errors++; $display("FAIL load scan det3: got %b want 0", det3); end
        if (full3 !== 1'b1) begin errors++; $display("FAIL load scan full3: got %b want 1", full3); end
        send_bit(1'b1);
        send_bit(1'b1);
        checks += 2;
        if (det3 !== 1'b1) begin errors++; $display("FAIL load new pat det3: got %b want 1", det3); end
        if (cnt3 !== 8'(CntOn)) begin
            errors++;
            $display("FAIL load new pat cnt3: got %0d want %0d", cnt3, CntOn);
        end
    endtask

    // en low holds MATCH; rst while detect=1 and en=0 restores reset values and PAT_RST.
    task automatic test_rst_during_match();
        en        = 1'b0;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        step();
        step();
        checks += 3;
        if (det3 !== 1'b1)  begin errors++; $display("FAIL en hold det3: got %b want 1", det3); end
        if (full3 !== 1'b1) begin errors++; $display("FAIL en hold full3: got %b want 1", full3); end
        if (cnt3 !== 8'(CntOn)) begin
            errors++;
            $display("FAIL en hold cnt3: got %0d want %0d", cnt3, CntOn);
        end
        rst = 1'b1;
        step();
        rst       = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        checks += 3;
        if (det3 !== 1'b0)  begin errors++; $display("FAIL rst det3: got %b want 0", det3); end
        if (full3 !== 1'b0) begin errors++; $display("FAIL rst full3: got %b want 0", full3); end
        if (cnt3 !== 8'd0)  begin errors++; $display("FAIL rst cnt3: got %0d want 0", cnt3); end
        en      = 1'b1;
        overlap = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (det3 !== 1'b0) begin errors++; $display("FAIL rst pat det3 mid: got %b want 0", det3); end
        send_bit(1'b1);
        checks++;
        if (det3 !== 1'b1) begin errors++; $display("FAIL rst pat restored det3: got %b want 1", det3); end
    endtask

    initial begin
        test_reset();
        test_overlap_mode(1'b1);
        test_overlap_mode(1'b0);
        test_gaps();
        test_saturate();
        test_load_priority();
        test_rst_during_match();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
